// File: rtl/execute_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution,
// and the EX/MEM pipeline register feeding the memory stage.
module execute_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            reg_write_e,
    input  logic [1:0]      result_src_e,
    input  logic            mem_write_e,
    input  logic            jump_e,
    input  logic            jalr_e,
    input  logic            branch_e,
    input  logic [2:0]      funct3_e,
    input  logic [2:0]      alu_control_e,
    input  logic            alu_src_e,
    input  logic [XLEN-1:0] rd1_e,
    input  logic [XLEN-1:0] rd2_e,
    input  logic [XLEN-1:0] imm_ext_e,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] pc_plus4_e,
    input  logic [4:0]      rd_e,
    input  logic [1:0]      forward_a_e,
    input  logic [1:0]      forward_b_e,
    input  logic [XLEN-1:0] result_w,
    output logic            pc_src_e,
    output logic [XLEN-1:0] pc_target_e,
    output logic            reg_write_m,
    output logic            mem_write_m,
    output logic [1:0]      result_src_m,
    output logic [XLEN-1:0] alu_result_m,
    output logic [XLEN-1:0] write_data_m,
    output logic [XLEN-1:0] pc_plus4_m,
    output logic [4:0]      rd_m
);

    localparam int unsigned SHAMT_W = 5;

    logic            r_reg_write;
    logic            r_mem_write;
    logic [1:0]      r_result_src;
    logic [XLEN-1:0] r_alu_result;
    logic [XLEN-1:0] r_write_data;
    logic [XLEN-1:0] r_pc_plus4;
    logic [4:0]      r_rd;

    logic [XLEN-1:0] w_src_a;
    logic [XLEN-1:0] w_fwd_b;
    logic [XLEN-1:0] w_src_b;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_jalr_sum;
    logic            w_taken;
    logic            w_eq;
    logic            w_lt;
    logic            w_ltu;

    // Forwarding muxes; select 10 reads the registered EX/MEM value, so no loop.
    always_comb begin
        w_src_a = rd1_e;
        w_fwd_b = rd2_e;
        case (forward_a_e)
            2'b01:   w_src_a = result_w;
            2'b10:   w_src_a = r_alu_result;
            default: w_src_a = rd1_e;
        endcase
        case (forward_b_e)
            2'b01:   w_fwd_b = result_w;
            2'b10:   w_fwd_b = r_alu_result;
            default: w_fwd_b = rd2_e;
        endcase
        w_src_b = alu_src_e ? imm_ext_e : w_fwd_b;
    end

    always_comb begin
        w_alu = '0;
        case (alu_control_e)
            3'b000: w_alu = w_src_a + w_src_b;
            3'b001: w_alu = w_src_a - w_src_b;
            3'b010: w_alu = w_src_a & w_src_b;
            3'b011: w_alu = w_src_a | w_src_b;
            3'b100: w_alu = w_src_a ^ w_src_b;
            3'b101: w_alu = XLEN'($signed(w_src_a) < $signed(w_src_b));
            3'b110: w_alu = w_src_a << w_src_b[SHAMT_W-1:0];
            3'b111: w_alu = w_src_a >> w_src_b[SHAMT_W-1:0];
            default: w_alu = '0;
        endcase
    end

    // Branch compare always uses the forwarded register operands, never the immediate.
    always_comb begin
        w_eq    = (w_src_a == w_fwd_b);
        w_lt    = ($signed(w_src_a) < $signed(w_fwd_b));
        w_ltu   = (w_src_a < w_fwd_b);
        w_taken = 1'b0;
        case (funct3_e)
            3'b000:  w_taken = w_eq;
            3'b001:  w_taken = !w_eq;
            3'b100:  w_taken = w_lt;
            3'b101:  w_taken = !w_lt;
            3'b110:  w_taken = w_ltu;
            3'b111:  w_taken = !w_ltu;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_jalr_sum  = w_src_a + imm_ext_e;
        pc_src_e    = jump_e | (branch_e & w_taken);
        pc_target_e = jalr_e ? {w_jalr_sum[XLEN-1:1], 1'b0} : (pc_e + imm_ext_e);
    end

    // EX/MEM pipeline register; no stall, reset drops the in-flight instruction.
    always_ff @(posedge clk) begin
        if (srst) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_result_src <= 2'b00;
            r_alu_result <= '0;
            r_write_data <= '0;
            r_pc_plus4   <= '0;
            r_rd         <= 5'd0;
        end else begin
            r_reg_write  <= reg_write_e;
            r_mem_write  <= mem_write_e;
            r_result_src <= result_src_e;
            r_alu_result <= w_alu;
            r_write_data <= w_fwd_b;
            r_pc_plus4   <= pc_plus4_e;
            r_rd         <= rd_e;
        end
    end

    assign reg_write_m  = r_reg_write;
    assign mem_write_m  = r_mem_write;
    assign result_src_m = r_result_src;
    assign alu_result_m = r_alu_result;
    assign write_data_m = r_write_data;
    assign pc_plus4_m   = r_pc_plus4;
    assign rd_m         = r_rd;

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage RV32I pipeline, directly downstream of the decode stage's ID/EX register.
- Resolves operand forwarding, computes the ALU result, and evaluates the branch condition and target (PC-relative or jalr).
- Drives pc_src_e/pc_target_e back to fetch.
- Registers the EX/MEM pipeline register consumed by the memory stage.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock, all registers rise-edge
- srst  in  1  synchronous active-high reset
- reg_write_e  in  1  ID/EX register-write enable
- result_src_e  in  2  ID/EX writeback select, passed through
- mem_write_e  in  1  ID/EX store enable
- jump_e  in  1  jal/jalr
- jalr_e  in  1  jump is register-indirect
- branch_e  in  1  conditional branch
- funct3_e  in  3  branch type
- alu_control_e  in  3  ALU op
- alu_src_e  in  1  0: src_b = forwarded rd2; 1: src_b = imm_ext_e
- rd1_e, rd2_e  in  32  register-file read data
- imm_ext_e  in  32  sign-extended immediate
- pc_e, pc_plus4_e  in  32  instruction PC, PC+4
- rd_e  in  5  destination register
- forward_a_e, forward_b_e  in  2  hazard-unit forward selects
- result_w  in  32  writeback-stage result
- pc_src_e  out  1  redirect fetch (combinational)
- pc_target_e  out  32  redirect address (combinational)
- reg_write_m, mem_write_m  out  1  EX/MEM control
- result_src_m  out  2  EX/MEM control
- alu_result_m, write_data_m, pc_plus4_m  out  32  EX/MEM data
- rd_m  out  5  EX/MEM destination

Behaviour:
- Forwarding, separately for A and B:
  - 00 selects rd1_e/rd2_e.
  - 01 selects result_w.
  - 10 selects alu_result_m (the internal EX/MEM register output).
  - 11 is reserved and treated as 00.
- src_a = forwarded A. src_b = imm_ext_e if alu_src_e, else forwarded B.
- ALU, all 32-bit with wrap-around and no overflow flag:
  - 000 add; 001 sub; 010 and; 011 or; 100 xor.
  - 101 slt (signed, result 0/1).
  - 110 sll by src_b[4:0]; 111 srl (logical) by src_b[4:0].
- Branch compare uses forwarded A vs forwarded B, never the immediate:
  - funct3 000 beq; 001 bne; 100 blt; 101 bge; 110 bltu; 111 bgeu.
  - funct3 010/011 → not taken.
- pc_src_e = jump_e | (branch_e & taken). It is 0 whenever jump_e = branch_e = 0, including after reset when the ID/EX inputs are zero.
- pc_target_e:
  - jalr_e = 1: (src_a + imm_ext_e) with bit 0 cleared.
  - otherwise: pc_e + imm_ext_e.
  - pc_target_e is valid whenever pc_src_e = 1.
- EX/MEM register, captured every rising edge with no stall input:
  - reg_write_m, result_src_m, mem_write_m, rd_m, pc_plus4_m copy their _e inputs.
  - alu_result_m = ALU output.
  - write_data_m = forwarded B, pre-immediate mux.
- Latency: combinational outputs in the same cycle; EX/MEM outputs 1 cycle.
- Flushing is performed upstream by zeroing the ID/EX register. A bubble enters as all-zero controls and must produce reg_write_m = mem_write_m = 0.
- srst = 1 at an edge sets every EX/MEM output to 0. This includes a reset mid-stream; the in-flight instruction is dropped.
- Back-to-back dependent instructions: forward select 10 uses the value registered on the previous edge, never the current ALU output, so there is no combinational loop.
- jal writes pc_plus4_m. The ALU result for jumps is don't-care but must still be deterministic: the computed ALU value is registered.

Test Plan:
- Bubble: all inputs 0 → pc_src_e = 0; after one edge all _m outputs 0.
- Add with EX/MEM forwarding: cycle n rd1 = 5, imm = 7, alu_src = 1, op 000 → alu_result_m = 12. Cycle n+1 forward_a = 10, rd2 = 3, op 001 → alu_result_m = 9.
- Writeback forwarding and store data: forward_b = 01, result_w = 0xDEADBEEF, alu_src = 1, mem_write = 1 → write_data_m = 0xDEADBEEF, mem_write_m = 1.
- Branches: blt with A = 0xFFFFFFFF, B = 1 → pc_src_e = 1, pc_target_e = pc_e + imm. bltu with the same operands → pc_src_e = 0. bne with equal operands → 0.
- jalr: jump_e = jalr_e = 1, A = 0x1001, imm = 4 → pc_target_e = 0x1004, pc_src_e = 1. Next edge pc_plus4_m = pc_e + 4.
- Reset mid-stream: srst pulsed while reg_write_e = 1, alu result 0x55 → all _m = 0 that edge. Next edge resumes normally. Also check forward select 11 behaves as 00 and shift by 33 equals shift by 1.
